// File: rtl/player_pkg.sv
// Shared types and screen geometry for the player motion block.
package player_pkg;

   typedef enum logic [1:0] {
      GROUNDED = 2'd0,
      RISING   = 2'd1,
      FALLING  = 2'd2
   } motion_state_t;

   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;
   localparam int SPRITE_SZ = 16;

endpackage

// File: rtl/player_motion_sat_add_s.sv
// Signed add with constant min/max clamp; flags report a result at or beyond each limit.
module sat_add_s #(
   parameter int W  = 8,
   parameter int LO = -128,
   parameter int HI = 127
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] q,
   output logic                hit_lo,
   output logic                hit_hi
);

   localparam logic signed [W:0] LO_S = (W+1)'(LO);
   localparam logic signed [W:0] HI_S = (W+1)'(HI);

   logic signed [W:0] sum;

   // One guard bit so the raw sum can never wrap before the clamp compare.
   assign sum    = {a[W-1], a} + {b[W-1], b};
   assign hit_lo = (sum <= LO_S);
   assign hit_hi = (sum >= HI_S);

   always_comb begin
      q = sum[W-1:0];
      if (hit_lo)
         q = LO_S[W-1:0];
      else if (hit_hi)
         q = HI_S[W-1:0];
   end

endmodule

// File: rtl/player_motion.sv
// Per-frame player physics: walk, jump, gravity and landing for the platform game.
module player_motion
   import player_pkg::*;
#(
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int V_W       = 5,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = SCREEN_W - SPRITE_SZ - 1,
   parameter int Y_MIN     = 0,
   parameter int Y_MAX     = SCREEN_H - SPRITE_SZ - 1,
   parameter int X_RESET   = 100,
   parameter int Y_RESET   = 100,
   parameter int WALK_STEP = 2,
   parameter int JUMP_VEL  = 8,
   parameter int GRAVITY   = 1,
   parameter int MAX_FALL  = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  left_press,
   input  logic                  right_press,
   input  logic                  jump,
   input  logic                  on_platform,
   output logic [X_W-1:0]        x,
   output logic [Y_W-1:0]        y,
   output logic signed [V_W-1:0] vy,
   output logic [1:0]            state,
   output logic                  airborne
);

   localparam logic [X_W-1:0]        X_RST    = X_W'(X_RESET);
   localparam logic [Y_W-1:0]        Y_RST    = Y_W'(Y_RESET);
   localparam logic [Y_W-1:0]        Y_MIN_V  = Y_W'(Y_MIN);
   localparam logic [Y_W-1:0]        Y_MAX_V  = Y_W'(Y_MAX);
   localparam logic signed [X_W:0]   STEP_POS = (X_W+1)'(WALK_STEP);
   localparam logic signed [X_W:0]   STEP_NEG = (X_W+1)'(-WALK_STEP);
   localparam logic signed [V_W-1:0] V_LAUNCH = V_W'(-JUMP_VEL);
   localparam logic signed [V_W-1:0] V_GRAV   = V_W'(GRAVITY);

   motion_state_t st, st_n;
   logic          jump_armed, launch;

   logic signed [X_W:0]   x_a, x_step, x_q;
   logic signed [Y_W:0]   y_a, y_b, y_q;
   logic signed [V_W-1:0] vy_inc, vy_n;
   logic [Y_W-1:0]        y_n;
   logic                  x_lo, x_hi, y_lo, y_hi, v_lo, v_hi;
   logic                  unused_bits;

   assign x_a = {1'b0, x};
   assign y_a = {1'b0, y};
   assign y_b = {{(Y_W + 1 - V_W){vy[V_W-1]}}, vy};

   always_comb begin
      x_step = '0;
      if (left_press && !right_press)
         x_step = STEP_NEG;
      else if (right_press && !left_press)
         x_step = STEP_POS;
   end

   sat_add_s #(.W(X_W + 1), .LO(X_MIN), .HI(X_MAX)) u_x_add (
      .a(x_a), .b(x_step), .q(x_q), .hit_lo(x_lo), .hit_hi(x_hi)
   );

   sat_add_s #(.W(Y_W + 1), .LO(Y_MIN), .HI(Y_MAX)) u_y_add (
      .a(y_a), .b(y_b), .q(y_q), .hit_lo(y_lo), .hit_hi(y_hi)
   );

   sat_add_s #(.W(V_W), .LO(-(2 ** (V_W - 1))), .HI(MAX_FALL)) u_vy_add (
      .a(vy), .b(V_GRAV), .q(vy_inc), .hit_lo(v_lo), .hit_hi(v_hi)
   );

   // Clamp flags for x/vy and the always-zero guard bits are not needed downstream.
   assign unused_bits = ^{x_lo, x_hi, v_lo, v_hi, x_q[X_W], y_q[Y_W]};

   always_comb begin
      st_n   = st;
      y_n    = y;
      vy_n   = vy;
      launch = 1'b0;
      case (st)
         GROUNDED: begin
            vy_n = '0;
            if (jump && jump_armed) begin
               launch = 1'b1;
               vy_n   = V_LAUNCH;
               st_n   = RISING;
            end else if (!on_platform && y != Y_MAX_V) begin
               st_n = FALLING;
            end
         end
         RISING: begin
            if (y_lo) begin
               y_n  = Y_MIN_V;
               vy_n = '0;
               st_n = FALLING;
            end else begin
               y_n  = y_q[Y_W-1:0];
               vy_n = vy_inc;
               if (!vy_inc[V_W-1])
                  st_n = FALLING;
            end
         end
         FALLING: begin
            if (on_platform) begin
               vy_n = '0;
               st_n = GROUNDED;
            end else if (y_hi) begin
               y_n  = Y_MAX_V;
               vy_n = '0;
               st_n = GROUNDED;
            end else begin
               y_n  = y_q[Y_W-1:0];
               vy_n = vy_inc;
            end
         end
         default: begin
            vy_n = '0;
            st_n = FALLING;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x          <= X_RST;
         y          <= Y_RST;
         vy         <= '0;
         st         <= FALLING;
         airborne   <= 1'b1;
         jump_armed <= 1'b0;
      end else if (tick) begin
         x          <= x_q[X_W-1:0];
         y          <= y_n;
         vy         <= vy_n;
         st         <= st_n;
         airborne   <= (st_n != GROUNDED);
         jump_armed <= !jump || (jump_armed && !launch);
      end
   end

   assign state = st;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion against an integer physics model.
module tb_player_motion;
   import player_pkg::*;

   logic             clk, reset, tick;
   logic             left_press, right_press, jump, on_platform;
   logic [9:0]       x;
   logic [8:0]       y;
   logic signed [4:0] vy;
   logic [1:0]       state;
   logic             airborne;

   int ncmp = 0;
   int nerr = 0;

   int            mx, my, mvy;
   motion_state_t ms;
   bit            marmed;

   player_motion #(
      .X_W(10), .Y_W(9), .V_W(5), .X_MIN(0), .X_MAX(623), .Y_MIN(0), .Y_MAX(463),
      .X_RESET(100), .Y_RESET(100), .WALK_STEP(2), .JUMP_VEL(8), .GRAVITY(1), .MAX_FALL(6)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .left_press(left_press), .right_press(right_press), .jump(jump),
      .on_platform(on_platform),
      .x(x), .y(y), .vy(vy), .state(state), .airborne(airborne)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [26:0] dut_vec();
      return {x, y, vy, state, airborne};
   endfunction

   function automatic logic [26:0] model_vec();
      return {10'(mx), 9'(my), 5'(mvy), 2'(ms), ms != GROUNDED};
   endfunction

   function automatic void model_reset();
      mx = 100; my = 100; mvy = 0; ms = FALLING; marmed = 0;
   endfunction

   function automatic void model_step(input bit l, input bit r, input bit j, input bit p);
      int  yn, vn;
      bit  launched;
      launched = 0;
      if (l && !r)      mx = (mx - 2 < 0)   ? 0   : mx - 2;
      else if (r && !l) mx = (mx + 2 > 623) ? 623 : mx + 2;
      case (ms)
         GROUNDED: begin
            if (j && marmed) begin
               launched = 1; mvy = -8; ms = RISING;
            end else begin
               mvy = 0;
               if (!p && my != 463) ms = FALLING;
            end
         end
         RISING: begin
            yn = my + mvy; vn = mvy + 1;
            if (yn <= 0) begin
               my = 0; mvy = 0; ms = FALLING;
            end else begin
               my = yn; mvy = vn;
               if (vn >= 0) ms = FALLING;
            end
         end
         default: begin
            if (p) begin
               ms = GROUNDED; mvy = 0;
            end else begin
               yn = my + mvy; vn = (mvy + 1 > 6) ? 6 : mvy + 1;
               if (yn >= 463) begin
                  my = 463; mvy = 0; ms = GROUNDED;
               end else begin
                  my = yn; mvy = vn;
               end
            end
         end
      endcase
      if (!j) marmed = 1;
      else if (launched) marmed = 0;
   endfunction

   task automatic step(input bit l, input bit r, input bit j, input bit p);
      @(negedge clk);
      left_press = l; right_press = r; jump = j; on_platform = p; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      model_step(l, r, j, p);
   endtask

   task automatic test_reset();
      reset = 1'b1; tick = 1'b0;
      left_press = 0; right_press = 0; jump = 0; on_platform = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      ncmp++;
      if (dut_vec() !== {10'd100, 9'd100, 5'd0, 2'(FALLING), 1'b1}) begin
         nerr++; $display("FAIL reset: got %h want %h", dut_vec(), {10'd100, 9'd100, 5'd0, 2'(FALLING), 1'b1});
      end
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 0);
         ncmp++;
         if (dut_vec() !== model_vec()) begin
            nerr++; $display("FAIL first_fall t%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
      ncmp++;
      if (y !== 9'd101 || vy !== 5'sd2 || state !== 2'(FALLING)) begin
         nerr++; $display("FAIL first_fall_y: got y=%0d vy=%0d st=%0d want y=101 vy=2 st=%0d", y, vy, state, FALLING);
      end
   endtask

   task automatic test_tick_gating();
      logic [26:0] held;
      held = dut_vec();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         left_press = 1'($urandom); right_press = 1'($urandom);
         jump = 1'($urandom); on_platform = 1'($urandom);
      end
      @(negedge clk);
      ncmp++;
      if (dut_vec() !== model_vec() || dut_vec() !== held) begin
         nerr++; $display("FAIL tick_gating: got %h want %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_fall_and_land();
      int maxv = 0;
      int n = 0;
      while (ms != GROUNDED && n < 200) begin
         step(0, 0, 0, 0);
         n++;
         if (int'(vy) > maxv) maxv = int'(vy);
         ncmp++;
         if (dut_vec() !== model_vec()) begin
            nerr++; $display("FAIL fall t%0d: got %h want %h", n, dut_vec(), model_vec());
         end
      end
      ncmp++;
      if (maxv != 6) begin
         nerr++; $display("FAIL terminal_vy: got %0d want 6", maxv);
      end
      ncmp++;
      if (y !== 9'd463 || vy !== 5'sd0 || state !== 2'(GROUNDED) || airborne !== 1'b0) begin
         nerr++; $display("FAIL landing: got y=%0d vy=%0d st=%0d air=%0b want y=463 vy=0 st=0 air=0", y, vy, state, airborne);
      end
   endtask

   task automatic test_jump_apex();
      for (int i = 0; i < 9; i++) begin
         step(0, 0, i == 0, 0);
         ncmp++;
         if (dut_vec() !== model_vec()) begin
            nerr++; $display("FAIL jump t%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
      ncmp++;
      if (y !== 9'd427 || vy !== 5'sd0 || state !== 2'(FALLING)) begin
         nerr++; $display("FAIL jump_apex: got y=%0d vy=%0d st=%0d want y=427 vy=0 st=%0d", y, vy, state, FALLING);
      end
      for (int i = 0; i < 40 && ms != GROUNDED; i++) step(0, 0, 0, 0);
   endtask

   task automatic test_jump_hold();
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 1, 0);
         ncmp++;
         if (dut_vec() !== model_vec()) begin
            nerr++; $display("FAIL jump_hold t%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
      ncmp++;
      if (state !== 2'(GROUNDED) || y !== 9'd463) begin
         nerr++; $display("FAIL no_repeat: got st=%0d y=%0d want st=0 y=463", state, y);
      end
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      ncmp++;
      if (state !== 2'(RISING) || vy !== -5'sd8) begin
         nerr++; $display("FAIL rearm: got st=%0d vy=%0d want st=%0d vy=-8", state, vy, RISING);
      end
      for (int i = 0; i < 40 && ms != GROUNDED; i++) step(0, 0, 0, 0);
   endtask

   task automatic test_walk_limits();
      int n = 0;
      for (int i = 0; i < 270; i++) step(0, 1, 0, 0);
      ncmp++;
      if (dut_vec() !== model_vec() || x !== 10'd623) begin
         nerr++; $display("FAIL right_limit: got %h (x=%0d) want %h (x=623)", dut_vec(), x, model_vec());
      end
      while (mx != 3 && n < 400) begin
         step(1, 0, 0, 0);
         n++;
         ncmp++;
         if (dut_vec() !== model_vec()) begin
            nerr++; $display("FAIL walk_left t%0d: got %h want %h", n, dut_vec(), model_vec());
         end
      end
      step(1, 0, 0, 0);
      ncmp++;
      if (x !== 10'd1) begin nerr++; $display("FAIL left_to_1: got %0d want 1", x); end
      step(1, 0, 0, 0);
      ncmp++;
      if (x !== 10'd0) begin nerr++; $display("FAIL left_to_0: got %0d want 0", x); end
      step(1, 0, 0, 0);
      ncmp++;
      if (x !== 10'd0) begin nerr++; $display("FAIL left_hold_0: got %0d want 0", x); end
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      step(1, 1, 0, 0);
      ncmp++;
      if (x !== 10'd10 || dut_vec() !== model_vec()) begin
         nerr++; $display("FAIL both_pressed: got x=%0d want 10", x);
      end
   endtask

   task automatic test_platform();
      int yb;
      step(0, 0, 1, 0);
      while (ms == RISING) begin
         step(0, 0, 0, 1);
         ncmp++;
         if (dut_vec() !== model_vec()) begin
            nerr++; $display("FAIL rise_thru_platform: got %h want %h", dut_vec(), model_vec());
         end
      end
      repeat (3) step(0, 0, 0, 0);
      yb = my;
      step(0, 0, 0, 1);
      ncmp++;
      if (state !== 2'(GROUNDED) || vy !== 5'sd0 || int'(y) != yb || dut_vec() !== model_vec()) begin
         nerr++; $display("FAIL platform_land: got st=%0d y=%0d vy=%0d want st=0 y=%0d vy=0", state, y, vy, yb);
      end
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      ncmp++;
      if (state !== 2'(FALLING) || vy !== 5'sd0 || int'(y) != yb || airborne !== 1'b1) begin
         nerr++; $display("FAIL walk_off: got st=%0d y=%0d vy=%0d want st=%0d y=%0d vy=0", state, y, vy, FALLING, yb);
      end
      for (int i = 0; i < 60 && ms != GROUNDED; i++) step(0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_jump();
      step(0, 0, 1, 0);
      repeat (3) step(0, 0, 1, 0);
      @(negedge clk);
      reset = 1'b1; tick = 1'b1; jump = 1'b1; right_press = 1'b1;
      @(negedge clk);
      reset = 1'b0; tick = 1'b0;
      model_reset();
      ncmp++;
      if (dut_vec() !== {10'd100, 9'd100, 5'd0, 2'(FALLING), 1'b1}) begin
         nerr++; $display("FAIL reset_mid_jump: got %h want %h", dut_vec(), {10'd100, 9'd100, 5'd0, 2'(FALLING), 1'b1});
      end
   endtask

   task automatic test_random();
      bit l, r, j, p;
      for (int i = 0; i < 600; i++) begin
         l = 1'($urandom); r = 1'($urandom); j = 1'($urandom);
         p = ($urandom_range(0, 7) == 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         step(l, r, j, p);
         ncmp++;
         if (dut_vec() !== model_vec()) begin
            nerr++; $display("FAIL random t%0d: got %h want %h", i, dut_vec(), model_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_tick_gating();
      test_fall_and_land();
      test_jump_apex();
      test_jump_hold();
      test_walk_limits();
      test_platform();
      test_reset_mid_jump();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
